// File: rtl/mul_iter_booth.sv
// mul_iter_booth: iterative radix-4 Booth multiplier for the RV64M execute stage.
// Two Booth partial products per cycle are folded into a carry-save accumulator
// through a 4:2 compressor (csa4). One final carry-propagate add then yields the
// 2*XLEN-bit product. The op selects the low half (MUL) or the high half.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake; in_ready is high only in IDLE
//   in_op                 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   in_a, in_b, in_tag    operands (rs1, rs2) and destination tag
//   flush                 abort any in-flight or held operation
//   out_valid / out_ready result handshake
//   out_result, out_tag   selected product slice and tag of the request

// 4:2 carry-save compressor built from two 3:2 layers. The LSB of each carry
// vector is free, so cin and cin2 inject two independent +1 terms. These are the
// two's-complement corrections for negated Booth partial products.
module csa4 #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    input  logic         cin,
    input  logic         cin2,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);
    logic [W-1:0] s1;
    logic [W-1:0] c1;
    logic [W-2:0] m1;
    logic [W-2:0] m2;

    assign s1    = a ^ b ^ c;
    assign m1    = (a[W-2:0] & b[W-2:0]) | (a[W-2:0] & c[W-2:0]) | (b[W-2:0] & c[W-2:0]);
    assign c1    = {m1, cin};
    assign sum   = s1 ^ c1 ^ d;
    assign m2    = (s1[W-2:0] & c1[W-2:0]) | (s1[W-2:0] & d[W-2:0]) | (c1[W-2:0] & d[W-2:0]);
    assign carry = {m2, cin2};
endmodule

module mul_iter_booth #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);
    localparam int EW   = XLEN + 2;          // extended operand width
    localparam int MW   = EW + 1;            // multiplier with implicit b[-1]
    localparam int AW   = 2 * XLEN + 4;      // accumulator width
    localparam int ITER = (XLEN / 2 + 2) / 2;
    localparam int CW   = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {IDLE, BUSY, FINAL, DONE} state_t;

    state_t             state;
    logic [1:0]         op_q;
    logic [TAG_W-1:0]   tag_q;
    logic [CW-1:0]      cnt;
    logic [AW-1:0]      acc_sum;
    logic [AW-1:0]      acc_carry;
    logic [AW-1:0]      mcand;    // a, pre-shifted to the weight of the current digit pair
    logic [MW-1:0]      mplier;   // {b, 0}, arithmetic-shifted right four bits per cycle

    logic               a_sgn;
    logic               b_sgn;
    logic signed [EW-1:0] a_ext;
    logic signed [EW-1:0] b_ext;
    logic [AW-1:0]      pp0;
    logic [AW-1:0]      pp1;
    logic               neg0;
    logic               neg1;
    logic [AW-1:0]      csa_sum;
    logic [AW-1:0]      csa_carry;
    logic [2*XLEN-1:0]  prod;

    function automatic logic booth_neg(input logic [2:0] d);
        // 111 is digit 0, so it is not treated as a negation
        return d[2] & ~(d[1] & d[0]);
    endfunction

    // One's-complement partial product; the +1 of a negation is added separately
    function automatic logic [AW-1:0] booth_pp(input logic [2:0] d, input logic [AW-1:0] m);
        logic [AW-1:0] mag;
        case (d)
            3'b001, 3'b010, 3'b101, 3'b110: mag = m;
            3'b011, 3'b100:                 mag = m << 1;
            default:                        mag = '0;
        endcase
        return booth_neg(d) ? ~mag : mag;
    endfunction

    always_comb begin
        a_sgn = (in_op != 2'b11);
        b_sgn = ~in_op[1];
        a_ext = {{2{a_sgn & in_a[XLEN-1]}}, in_a};
        b_ext = {{2{b_sgn & in_b[XLEN-1]}}, in_b};
        neg0  = booth_neg(mplier[2:0]);
        neg1  = booth_neg(mplier[4:2]);
        pp0   = booth_pp(mplier[2:0], mcand);
        pp1   = booth_pp(mplier[4:2], mcand << 2);
        prod  = acc_sum[2*XLEN-1:0] + acc_carry[2*XLEN-1:0];
    end

    csa4 #(.W(AW)) u_csa4 (
        .a     (acc_sum),
        .b     (acc_carry),
        .c     (pp0),
        .d     (pp1),
        .cin   (neg0),
        .cin2  (neg1),
        .sum   (csa_sum),
        .carry (csa_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            op_q       <= '0;
            tag_q      <= '0;
            cnt        <= '0;
            acc_sum    <= '0;
            acc_carry  <= '0;
            mcand      <= '0;
            mplier     <= '0;
        end else if (flush) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state     <= BUSY;
                        in_ready  <= 1'b0;
                        op_q      <= in_op;
                        tag_q     <= in_tag;
                        cnt       <= '0;
                        acc_sum   <= '0;
                        acc_carry <= '0;
                        mcand     <= {{(AW - EW){a_ext[EW-1]}}, a_ext};
                        mplier    <= {b_ext, 1'b0};
                    end
                end
                BUSY: begin
                    acc_sum   <= csa_sum;
                    acc_carry <= csa_carry;
                    mcand     <= mcand << 4;
                    // sign fill makes the digit past the last real one decode as 0
                    mplier    <= {{4{mplier[MW-1]}}, mplier[MW-1:4]};
                    cnt       <= cnt + 1'b1;
                    if (cnt == LAST) state <= FINAL;
                end
                FINAL: begin
                    out_result <= (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                    out_tag    <= tag_q;
                    out_valid  <= 1'b1;
                    state      <= DONE;
                end
                default: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_iter_booth.sv
// Scoreboard bench for mul_iter_booth: the driver pushes expected results as
// requests are issued, and an independent monitor pops and compares on every
// output transfer.
module tb_mul_iter_booth;
    localparam int XLEN  = 64;
    localparam int TAG_W = 5;

    typedef struct {
        logic [XLEN-1:0]  res;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   stall_mode = 0;   // 0: always ready, 1: random stalls, 2: never ready

    mul_iter_booth #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [XLEN-1:0] ref_mul(input logic [1:0] op, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        logic signed [2*XLEN+1:0] sa;
        logic signed [2*XLEN+1:0] sb;
        logic signed [2*XLEN+1:0] p;
        sa = {{(XLEN+2){(op != 2'b11) & a[XLEN-1]}}, a};
        sb = {{(XLEN+2){(op[1] == 1'b0) & b[XLEN-1]}}, b};
        p  = sa * sb;
        return (op == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    // Waits for in_ready, presents one request and returns #1 after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [TAG_W-1:0] tag, input bit expect_out, input logic [XLEN-1:0] res);
        int   w;
        exp_t e;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_vec++;
            n_miss++;
            $display("FAIL issue_timeout: in_ready %0b, expected 1", in_ready);
            return;
        end
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        if (expect_out) begin
            e.res = res;
            e.tag = tag;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    // Monitor: owns out_ready and compares every transfer against the scoreboard.
    initial begin
        exp_t e;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (stall_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_output: got result %h tag %0d, expected no output",
                             out_result, out_tag);
                end else begin
                    e = exp_q.pop_front();
                    check("result", out_result, e.res);
                    check("tag", XLEN'(out_tag), XLEN'(e.tag));
                end
            end
        end
    end

    initial begin
        int   w;
        logic [1:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [TAG_W-1:0] tag;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_op    = 2'b00;
        in_a     = '0;
        in_b     = '0;
        in_tag   = '0;
        flush    = 1'b0;
        #12;
        check("reset_in_ready", XLEN'(in_ready), 1);
        check("reset_out_valid", XLEN'(out_valid), 0);
        check("reset_out_result", out_result, 0);
        check("reset_out_tag", XLEN'(out_tag), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic MUL with exact latency: out_valid first seen after edge N+18.
        issue(2'b00, 64'd3, 64'd5, 5'd7, 1'b1, 64'd15);
        check("busy_in_ready", XLEN'(in_ready), 0);
        for (int i = 1; i <= 18; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("latency_c%0d", i), XLEN'(out_valid), XLEN'(i == 18));
        end

        issue(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        issue(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 1'b1, 64'h0000_0000_0000_0001);
        issue(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 1'b1, 64'h0);
        issue(2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd4, 1'b1, 64'h4000_0000_0000_0000);
        issue(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(2'b00, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 5'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);       // -3*7
        issue(2'b01, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 5'd8, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);       // high of -21
        issue(2'b11, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 5'd9, 1'b1, 64'h1);       // 2^32*2^32

        // Flush nine cycles after acceptance; the result must never appear.
        issue(2'b00, 64'd100, 64'd100, 5'd10, 1'b0, 64'h0);
        repeat (8) @(posedge clk);
        #1;
        pulse_flush();
        check("flush_in_ready", XLEN'(in_ready), 1);
        check("flush_out_valid", XLEN'(out_valid), 0);
        issue(2'b00, 64'd6, 64'd7, 5'd11, 1'b1, 64'd42);

        // Request presented together with flush is not accepted.
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        in_valid = 1'b1;
        in_op    = 2'b00;
        in_a     = 64'd9;
        in_b     = 64'd9;
        in_tag   = 5'd12;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_with_valid_in_ready", XLEN'(in_ready), 1);
        repeat (25) @(posedge clk);

        // Backpressure: result held for ten cycles, then one-cycle transfer.
        #1;
        stall_mode = 2;
        issue(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        w = 0;
        while (!out_valid && w < 40) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("stall_out_valid_rise", XLEN'(out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("stall_result", out_result, 64'hFFFF_FFFF_FFFF_FFFE);
            check("stall_tag", XLEN'(out_tag), 13);
            check("stall_in_ready", XLEN'(in_ready), 0);
        end
        stall_mode = 0;
        @(posedge clk);
        #1;
        check("release_out_valid", XLEN'(out_valid), 0);
        check("release_in_ready", XLEN'(in_ready), 1);

        // Asynchronous reset in BUSY clears outputs without waiting for an edge.
        issue(2'b00, 64'd5, 64'd5, 5'd14, 1'b0, 64'h0);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_in_ready", XLEN'(in_ready), 1);
        check("async_rst_out_valid", XLEN'(out_valid), 0);
        check("async_rst_out_result", out_result, 0);
        check("async_rst_out_tag", XLEN'(out_tag), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random regression against a 128-bit reference, with stalls and flushes.
        stall_mode = 1;
        for (int n = 0; n < 250; n++) begin
            op  = 2'($urandom_range(0, 3));
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            tag = TAG_W'(n);
            if (n % 5 == 0) a = {{56{a[63]}}, a[7:0]};
            if (n % 7 == 0) b = {{60{b[63]}}, b[3:0]};
            if ($urandom_range(0, 15) == 0) begin
                issue(op, a, b, tag, 1'b0, 64'h0);
                repeat ($urandom_range(0, 14)) @(posedge clk);
                #1;
                pulse_flush();
                check("rand_flush_in_ready", XLEN'(in_ready), 1);
            end else begin
                issue(op, a, b, tag, 1'b1, ref_mul(op, a, b));
            end
        end

        stall_mode = 0;
        w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            @(posedge clk);
            w++;
        end
        check("drain_pending", XLEN'(exp_q.size()), 0);
        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
